// File: rtl/setup_stream_ctrl.sv
// setup_stream_ctrl
//   Front end of the descriptor trace path. Collects an 8-byte SETUP packet
//   one byte per transfer, decodes bRequest/wLength and, for GET_DESCRIPTOR
//   (bRequest = 8'h06), walks the bit index `select` over the requested
//   descriptor bits under a valid/ready handshake.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   byte_in/byte_valid  SETUP byte stream in; byte_ready high in IDLE/COLLECT
//   bRequest, wLength   captured SETUP fields (wLength little-endian)
//   select, bit_valid   bit index handed downstream; bit_ready consumes it
//   busy                state is not IDLE
//   done                one-cycle pulse after the final bit handshake
//   stall               one-cycle pulse on a rejected SETUP
//
// Configuration
//   SETUP_STALL_EN      when defined, stall pulses on rejection; otherwise
//                       stall is tied low and rejection silently returns to IDLE.
module setup_stream_ctrl #(
    parameter int DESC_BITS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [7:0]  bRequest,
    output logic [15:0] wLength,
    output logic [8:0]  select,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [16:0] MAX_BYTES = 17'(DESC_BITS / 8);
    localparam logic [7:0]  GET_DESC  = 8'h06;

    state_t      state_q, state_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  breq_q, breq_d;
    logic [15:0] wlen_q, wlen_d;
    logic [8:0]  select_q, select_d;

    logic        byte_xfer;
    logic [16:0] len_bytes;
    logic [16:0] len_bits;
    logic [16:0] last_sel;
    logic        reject;

    assign byte_xfer = byte_valid && byte_ready;

    // Clamp in 17 bits before scaling so wLength = 16'hFFFF cannot overflow.
    // wLength is stable for the whole stream, so this is valid in STREAM too.
    always_comb begin
        len_bytes = ({1'b0, wlen_q} > MAX_BYTES) ? MAX_BYTES : {1'b0, wlen_q};
        len_bits  = len_bytes << 3;
        last_sel  = len_bits - 17'd1;
    end

    assign reject = (breq_q != GET_DESC) || (wlen_q == 16'd0);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        breq_d     = breq_q;
        wlen_d     = wlen_q;
        select_d   = select_q;
        case (state_q)
            S_IDLE: begin
                // Byte 0 (bmRequestType) plays no part in the decode.
                if (byte_xfer) begin
                    byte_cnt_d = 3'd1;
                    state_d    = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (byte_xfer) begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    case (byte_cnt_q)
                        3'd1:    breq_d = byte_in;
                        3'd6:    wlen_d[7:0]  = byte_in;
                        3'd7:    wlen_d[15:8] = byte_in;
                        default: ;
                    endcase
                    if (byte_cnt_q == 3'd7) state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (reject) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_STREAM;
                    select_d = 9'd0;
                end
            end
            S_STREAM: begin
                if (bit_ready) begin
                    if ({8'd0, select_q} == last_sel) state_d  = S_DONE;
                    else                              select_d = select_q + 9'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 3'd0;
            breq_q     <= 8'd0;
            wlen_q     <= 16'd0;
            select_q   <= 9'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            breq_q     <= breq_d;
            wlen_q     <= wlen_d;
            select_q   <= select_d;
        end
    end

`ifdef SETUP_STALL_EN
    logic stall_q, stall_d;

    // Registered so the pulse lands in the cycle after DECIDE.
    always_comb begin
        stall_d = (state_q == S_DECIDE) && reject;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= 1'b0;
        else       stall_q <= stall_d;
    end

    assign stall = stall_q;
`else
    assign stall = 1'b0;
`endif

    assign byte_ready = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign bit_valid  = (state_q == S_STREAM);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign bRequest   = breq_q;
    assign wLength    = wlen_q;
    assign select     = select_q;

endmodule

// File: tb/tb_setup_stream_ctrl.sv
module tb_setup_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  bRequest;
    logic [15:0] wLength;
    logic [8:0]  select;
    logic        bit_valid;
    logic        bit_ready;
    logic        busy;
    logic        done;
    logic        stall;

    int checks = 0;
    int errors = 0;

`ifdef SETUP_STALL_EN
    localparam logic STALL_EXP = 1'b1;
`else
    localparam logic STALL_EXP = 1'b0;
`endif

    setup_stream_ctrl #(.DESC_BITS(256)) dut (
        .clk(clk), .reset(reset),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .bRequest(bRequest), .wLength(wLength),
        .select(select), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    // Sends a full SETUP; returns with the time just after the byte-7 edge (DECIDE cycle).
    task automatic send_setup(input logic [7:0] req, input logic [15:0] wl, input logic rnd_gap);
        logic [7:0] pkt [8];
        pkt = '{8'h80, req, 8'h00, 8'h01, 8'h00, 8'h00, wl[7:0], wl[15:8]};
        for (int i = 0; i < 8; i++)
            send_byte(pkt[i], rnd_gap ? int'($urandom_range(1, 3)) : 0);
    endtask

    // Streams n bits with bit_ready held high, starting in the DECIDE cycle.
    task automatic stream_all(input string tag, input int n);
        bit_ready = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_sel"}, 32'(select), 32'(i));
            chk({tag, "_bv"}, 32'(bit_valid), 32'd1);
            tick();
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_bv_off"}, 32'(bit_valid), 32'd0);
        chk({tag, "_sel_last"}, 32'(select), 32'(n - 1));
        tick();
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_sel_hold"}, 32'(select), 32'(n - 1));
    endtask

    initial begin
        logic [3:0] pat;
        int hs;
        int exp_sel;
        int cyc;

        reset      = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        bit_ready  = 1'b0;
        #1;
        chk("rst_breq",  32'(bRequest),   32'h0);
        chk("rst_wlen",  32'(wLength),    32'h0);
        chk("rst_sel",   32'(select),     32'h0);
        chk("rst_bv",    32'(bit_valid),  32'h0);
        chk("rst_busy",  32'(busy),       32'h0);
        chk("rst_done",  32'(done),       32'h0);
        chk("rst_stall", 32'(stall),      32'h0);
        chk("rst_bready",32'(byte_ready), 32'h1);
        tick();
        reset = 1'b0;
        tick();

        // GET_DESCRIPTOR, wLength=2 -> 16 bits
        send_setup(8'h06, 16'h0002, 1'b0);
        chk("t1_breq",   32'(bRequest),   32'h06);
        chk("t1_wlen",   32'(wLength),    32'h0002);
        chk("t1_decide_busy", 32'(busy),  32'h1);
        chk("t1_decide_bready", 32'(byte_ready), 32'h0);
        chk("t1_decide_bv", 32'(bit_valid), 32'h0);
        stream_all("t1", 16);

        // wLength=0x40 clamps to 256 bits
        send_setup(8'h06, 16'h0040, 1'b0);
        stream_all("t2", 256);

        // wLength=0xFFFF also clamps to 256 bits
        send_setup(8'h06, 16'hFFFF, 1'b0);
        stream_all("t2f", 256);

        // Unsupported request
        bit_ready = 1'b1;
        send_setup(8'h05, 16'h0008, 1'b0);
        chk("t3_decide_bv", 32'(bit_valid), 32'h0);
        tick();
        chk("t3_stall",  32'(stall),     32'(STALL_EXP));
        chk("t3_bv",     32'(bit_valid), 32'h0);
        chk("t3_busy",   32'(busy),      32'h0);
        tick();
        chk("t3_stall_off", 32'(stall),  32'h0);

        // GET_DESCRIPTOR with wLength=0 is rejected too
        send_setup(8'h06, 16'h0000, 1'b0);
        tick();
        chk("t3z_stall", 32'(stall),     32'(STALL_EXP));
        chk("t3z_bv",    32'(bit_valid), 32'h0);
        chk("t3z_busy",  32'(busy),      32'h0);

        // wLength=1 with bit_ready pattern 1,0,0,1,...
        bit_ready = 1'b0;
        send_setup(8'h06, 16'h0001, 1'b0);
        tick();
        pat     = 4'b1001;   // bit0 used first: 1,0,0,1
        hs      = 0;
        exp_sel = 0;
        cyc     = 0;
        while (hs < 8 && cyc < 100) begin
            chk("t4_sel", 32'(select), 32'(exp_sel));
            chk("t4_bv",  32'(bit_valid), 32'h1);
            bit_ready = pat[cyc % 4];
            tick();
            if (pat[cyc % 4]) begin
                hs++;
                if (hs < 8) exp_sel++;
            end
            cyc++;
        end
        bit_ready = 1'b0;
        chk("t4_hs",   32'(hs),     32'd8);
        chk("t4_done", 32'(done),   32'h1);
        chk("t4_sel_end", 32'(select), 32'd7);
        tick();
        chk("t4_idle", 32'(busy),   32'h0);

        // Asynchronous reset while streaming at select=5
        send_setup(8'h06, 16'h0002, 1'b0);
        bit_ready = 1'b1;
        repeat (6) tick();
        chk("t5_pre_sel", 32'(select), 32'd5);
        #2 reset = 1'b1;
        #1;
        chk("t5_sel",   32'(select),     32'h0);
        chk("t5_bv",    32'(bit_valid),  32'h0);
        chk("t5_busy",  32'(busy),       32'h0);
        chk("t5_breq",  32'(bRequest),   32'h0);
        chk("t5_wlen",  32'(wLength),    32'h0);
        chk("t5_done",  32'(done),       32'h0);
        chk("t5_bready",32'(byte_ready), 32'h1);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        send_setup(8'h06, 16'h0001, 1'b0);
        stream_all("t5s", 8);

        // Random byte_valid gaps
        send_setup(8'h06, 16'h0003, 1'b1);
        chk("t6_breq", 32'(bRequest),  32'h06);
        chk("t6_wlen", 32'(wLength),   32'h0003);
        chk("t6_decide_bv", 32'(bit_valid), 32'h0);
        stream_all("t6", 24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/setup_stream_ctrl.md
# setup_stream_ctrl

Front-end stage of the descriptor trace path. It accepts the 8-byte SETUP packet one byte at a time and decodes bRequest and wLength. For GET_DESCRIPTOR (bRequest = 8'h06) it walks the bit index `select` through the requested descriptor bits, one per cycle, under a valid/ready handshake. Its outputs `bRequest` and `select` drive the bit-selecting trace stage directly downstream.

## Interface
Parameters:
- DESC_BITS, 256, descriptor size in bits; multiple of 8, at most 256.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- byte_in  input  8  SETUP byte.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  block accepts a byte this cycle.
- bRequest  output  8  captured bRequest (SETUP byte 1).
- wLength  output  16  captured wLength (bytes 6–7, little-endian).
- select  output  9  bit index presented downstream.
- bit_valid  output  1  select is valid.
- bit_ready  input  1  downstream consumed the current select.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse after the last bit.
- stall  output  1  one-cycle pulse on an unsupported request (only with SETUP_STALL_EN; otherwise tied 0).

## Operation
- States are IDLE, COLLECT, DECIDE, STREAM and DONE. Reset enters IDLE.
- Reset values: bRequest=0, wLength=0, select=0, bit_valid=0, busy=0, done=0, stall=0. byte_ready=1 (IDLE).
- byte_ready is 1 in IDLE and COLLECT and 0 in all other states. A byte transfers when byte_valid && byte_ready.
- IDLE:
  - A transfer stores byte 0 (bmRequestType) and sets byte_cnt=1.
  - The next state is COLLECT.
- COLLECT:
  - Each transfer stores the byte at index byte_cnt, then increments byte_cnt.
  - Byte 1 updates bRequest. Bytes 6 and 7 update wLength (low byte, then high byte). Bytes 2–5 are accepted and discarded.
  - Gaps in byte_valid are allowed; state and count hold.
  - Acceptance of byte 7 moves the state to DECIDE.
- DECIDE (exactly one cycle):
  - Compute len_bits = min(wLength, DESC_BITS/8) × 8, using a 17-bit intermediate so that wLength=16'hFFFF clamps correctly.
  - If bRequest==8'h06 and wLength!=0: go to STREAM with select=0.
  - Otherwise: go to IDLE. stall pulses in this case when SETUP_STALL_EN is defined.
- STREAM:
  - bit_valid=1.
  - On bit_valid && bit_ready: if select == len_bits−1, go to DONE; otherwise select increments by 1.
  - With bit_ready low, select holds.
  - select never wraps and never exceeds DESC_BITS−1.
- DONE:
  - done=1 for this cycle, then go to IDLE.
  - select, bRequest and wLength keep their values until the next SETUP byte 1 or 6/7 is captured.
- Asserting reset in any state returns the block to IDLE with reset values immediately (asynchronously). A partial SETUP is discarded.
- byte_valid is ignored in DECIDE, STREAM and DONE; no byte is consumed.

## Timing
- If byte 7 is accepted at clock edge N:
  - DECIDE occupies the cycle after edge N.
  - bit_valid and select=0 appear after edge N+1.
- With bit_ready held high, one index advances per cycle. The last index is presented len_bits−1 cycles after the first.
- done is high during the cycle immediately after the final handshake.
- stall is high during the cycle immediately after DECIDE.
- A new SETUP may start in the cycle after done or after stall.
- All outputs are registered or decoded from state only; there are no combinational paths from byte_valid or bit_ready.

## Configuration
- SETUP_STALL_EN defined:
  - The stall output pulses for one cycle when a completed SETUP is rejected (bRequest≠8'h06 or wLength=0).
- SETUP_STALL_EN undefined:
  - stall is constant 0. The rejection path still returns the block to IDLE.

## Test plan
- GET_DESCRIPTOR, wLength=2, bit_ready=1:
  - select steps 0..15 with bit_valid high for 16 cycles.
  - done pulses once; the block returns to IDLE.
- wLength=16'h0040, DESC_BITS=256:
  - Clamps to 256 bits; select ends at 255.
  - done pulses; no wrap to 0.
- bRequest=8'h05, wLength=8:
  - bit_valid stays 0.
  - stall pulses one cycle after DECIDE only when SETUP_STALL_EN is defined; busy returns to 0.
- GET_DESCRIPTOR, wLength=1, bit_ready toggling 1,0,0,1,…:
  - select holds while bit_ready=0.
  - Exactly 8 handshakes occur, ending at select=7.
- Reset asserted while in STREAM at select=5:
  - All outputs immediately take reset values.
  - A following full SETUP streams from select=0.
- SETUP bytes sent with random one-to-three-cycle byte_valid gaps:
  - bRequest and wLength are captured correctly.
  - Streaming starts two edges after byte 7 is accepted.
